// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises reset requests, holds every output asserted for a
// minimum time, then releases the outputs one at a time, bit 0 first.
module rst_sequencer #(
  parameter int P_NUM_REQ      = 2,
  parameter     P_REQ_POLARITY = {P_NUM_REQ{1'b1}},
  parameter int P_SYNC_STAGES  = 2,
  parameter int P_NUM_OUT      = 3,
  parameter     P_OUT_POLARITY = {P_NUM_OUT{1'b1}},
  parameter int P_HOLD_CYCLES  = 16,
  parameter int P_STAGE_GAP    = 8
) (
  input  logic                             i_sclk,
  input  logic                             i_srst_n,
  input  logic [P_NUM_REQ-1:0]             i_req,
  input  logic                             i_sw_rst,
  output logic [P_NUM_OUT-1:0]             o_srst,
  output logic [$clog2(P_NUM_OUT+1)-1:0]   o_stage,
  output logic                             o_done
);

  localparam int STAGE_W = $clog2(P_NUM_OUT + 1);
  localparam int CNT_MAX = (P_HOLD_CYCLES > P_STAGE_GAP) ? P_HOLD_CYCLES : P_STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [P_NUM_REQ-1:0] REQ_POL    = P_REQ_POLARITY;
  localparam logic [P_NUM_OUT-1:0] OUT_POL    = P_OUT_POLARITY;
  localparam logic [CNT_W-1:0]     HOLD_LOAD  = CNT_W'(P_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD   = CNT_W'(P_STAGE_GAP - 1);
  localparam logic [STAGE_W-1:0]   LAST_STAGE = STAGE_W'(P_NUM_OUT - 1);

  if (P_NUM_REQ < 1) begin : g_chk_num_req
    $error("rst_sequencer: P_NUM_REQ must be >= 1");
  end
  if (P_SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_sequencer: P_SYNC_STAGES must be >= 2");
  end
  if (P_NUM_OUT < 1) begin : g_chk_num_out
    $error("rst_sequencer: P_NUM_OUT must be >= 1");
  end
  if (P_HOLD_CYCLES < 1) begin : g_chk_hold
    $error("rst_sequencer: P_HOLD_CYCLES must be >= 1");
  end
  if (P_STAGE_GAP < 1) begin : g_chk_gap
    $error("rst_sequencer: P_STAGE_GAP must be >= 1");
  end
  if ($bits(P_REQ_POLARITY) != P_NUM_REQ) begin : g_chk_req_pol
    $error("rst_sequencer: P_REQ_POLARITY width must equal P_NUM_REQ");
  end
  if ($bits(P_OUT_POLARITY) != P_NUM_OUT) begin : g_chk_out_pol
    $error("rst_sequencer: P_OUT_POLARITY width must equal P_NUM_OUT");
  end

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_e;

  logic [P_NUM_REQ-1:0][P_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [P_NUM_REQ-1:0]                    req_norm;
  logic [P_NUM_REQ-1:0]                    req_last;
  logic                                    req_any;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic                 done_q, done_d;
  logic [P_NUM_OUT-1:0] srst_q, srst_d;

  // Requests are normalised to active-high before entering the synchroniser.
  assign req_norm = i_req ^ ~REQ_POL;

  always_comb begin
    sync_d   = sync_q;
    req_last = '0;
    for (int unsigned k = 0; k < P_NUM_REQ; k++) begin
      sync_d[k]   = {sync_q[k][P_SYNC_STAGES-2:0], req_norm[k]};
      req_last[k] = sync_q[k][P_SYNC_STAGES-1];
    end
  end

  assign req_any = (|req_last) | i_sw_rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    done_d  = done_q;
    srst_d  = srst_q;
    if (req_any) begin
      // Any request from any state restarts the whole hold-and-release sequence.
      state_d = ST_ASSERT;
      cnt_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
      srst_d  = OUT_POL;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            srst_d[0] = ~OUT_POL[0];
            stage_d   = STAGE_W'(1);
            cnt_d     = GAP_LOAD;
            if (P_NUM_OUT == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == '0) begin
            for (int unsigned k = 0; k < P_NUM_OUT; k++) begin
              if (STAGE_W'(k) == stage_q) srst_d[k] = ~OUT_POL[k];
            end
            stage_d = stage_q + STAGE_W'(1);
            cnt_d   = GAP_LOAD;
            if (stage_q == LAST_STAGE) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
        end
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_srst_n) begin
      sync_q  <= '1;
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      srst_q  <= OUT_POL;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      srst_q  <= srst_d;
    end
  end

  assign o_srst  = srst_q;
  assign o_stage = stage_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default, inverted-polarity and single-output instances,
// table-driven vectors plus hand-written corner sequences, checked via a scoreboard.
module tb_rst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic       a_srst_n, a_sw;
  logic [1:0] a_req;
  logic [2:0] a_srst;
  logic [1:0] a_stage;
  logic       a_done;

  // Mixed polarities
  logic       b_srst_n, b_sw;
  logic [1:0] b_req;
  logic [2:0] b_srst;
  logic [1:0] b_stage;
  logic       b_done;

  // Single output, one-cycle hold
  logic       c_srst_n, c_sw;
  logic [1:0] c_req;
  logic [0:0] c_srst;
  logic [0:0] c_stage;
  logic       c_done;

  rst_sequencer u_def (
    .i_sclk(clk), .i_srst_n(a_srst_n), .i_req(a_req), .i_sw_rst(a_sw),
    .o_srst(a_srst), .o_stage(a_stage), .o_done(a_done)
  );

  rst_sequencer #(
    .P_NUM_REQ(2), .P_REQ_POLARITY(2'b01), .P_NUM_OUT(3), .P_OUT_POLARITY(3'b010)
  ) u_pol (
    .i_sclk(clk), .i_srst_n(b_srst_n), .i_req(b_req), .i_sw_rst(b_sw),
    .o_srst(b_srst), .o_stage(b_stage), .o_done(b_done)
  );

  rst_sequencer #(
    .P_NUM_OUT(1), .P_HOLD_CYCLES(1)
  ) u_one (
    .i_sclk(clk), .i_srst_n(c_srst_n), .i_req(c_req), .i_sw_rst(c_sw),
    .o_srst(c_srst), .o_stage(c_stage), .o_done(c_done)
  );

  typedef struct {
    int unsigned n;
    logic        srst_n;
    logic [1:0]  req;
    logic        sw;
    logic [2:0]  e_srst;
    logic [1:0]  e_stage;
    logic        e_done;
    string       name;
  } vec_t;

  typedef struct {
    logic [2:0] srst;
    logic [1:0] stage;
    logic       done;
    string      name;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  function automatic void add_vec(input int unsigned n, input logic srst_n,
                                  input logic [1:0] req, input logic sw,
                                  input logic [2:0] es, input logic [1:0] est,
                                  input logic ed, input string name);
    vec_t v;
    v.n = n; v.srst_n = srst_n; v.req = req; v.sw = sw;
    v.e_srst = es; v.e_stage = est; v.e_done = ed; v.name = name;
    tbl.push_back(v);
  endfunction

  task automatic push_exp(input logic [2:0] srst, input logic [1:0] stage,
                          input logic done, input string name);
    exp_t e;
    e.srst = srst; e.stage = stage; e.done = done; e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_edges(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [2:0] srst, input logic [1:0] stage, input logic done);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: no expectation queued for srst=%b stage=%0d done=%b",
               srst, stage, done);
      return;
    end
    e = sb.pop_front();
    if (srst === e.srst && stage === e.stage && done === e.done) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got srst=%b stage=%0d done=%b, expected srst=%b stage=%0d done=%b",
               e.name, srst, stage, done, e.srst, e.stage, e.done);
    end
  endtask

  task automatic step_a(input int unsigned n, input logic [2:0] es, input logic [1:0] est,
                        input logic ed, input string name);
    push_exp(es, est, ed, name);
    wait_edges(n);
    check(a_srst, a_stage, a_done);
  endtask

  task automatic step_b(input int unsigned n, input logic [2:0] es, input logic [1:0] est,
                        input logic ed, input string name);
    push_exp(es, est, ed, name);
    wait_edges(n);
    check(b_srst, b_stage, b_done);
  endtask

  task automatic step_c(input int unsigned n, input logic es, input logic est,
                        input logic ed, input string name);
    push_exp({2'b00, es}, {1'b0, est}, ed, name);
    wait_edges(n);
    check({2'b00, c_srst}, {1'b0, c_stage}, c_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin
    a_srst_n = 1'b0; a_req = 2'b00; a_sw = 1'b0;
    b_srst_n = 1'b0; b_req = 2'b10; b_sw = 1'b0;
    c_srst_n = 1'b0; c_req = 2'b00; c_sw = 1'b0;

    // Default instance timeline; E0 is the third edge after reset release.
    add_vec(3,  1'b0, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "reset_state");
    add_vec(2,  1'b1, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "sync_hold_assert");
    add_vec(1,  1'b1, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "e0_still_asserted");
    add_vec(15, 1'b1, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "hold_e0p15");
    add_vec(1,  1'b1, 2'b00, 1'b0, 3'b110, 2'd1, 1'b0, "rel0_e0p16");
    add_vec(7,  1'b1, 2'b00, 1'b0, 3'b110, 2'd1, 1'b0, "gap_e0p23");
    add_vec(1,  1'b1, 2'b00, 1'b0, 3'b100, 2'd2, 1'b0, "rel1_e0p24");
    add_vec(7,  1'b1, 2'b00, 1'b0, 3'b100, 2'd2, 1'b0, "gap_e0p31");
    add_vec(1,  1'b1, 2'b00, 1'b0, 3'b000, 2'd3, 1'b1, "done_e0p32");
    add_vec(5,  1'b1, 2'b00, 1'b0, 3'b000, 2'd3, 1'b1, "done_steady");
    add_vec(2,  1'b1, 2'b10, 1'b0, 3'b000, 2'd3, 1'b1, "req1_in_sync");
    add_vec(1,  1'b1, 2'b10, 1'b0, 3'b111, 2'd0, 1'b0, "req1_reassert");
    add_vec(2,  1'b1, 2'b10, 1'b0, 3'b111, 2'd0, 1'b0, "req1_held");
    add_vec(3,  1'b1, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "req1_clear_e0");
    add_vec(15, 1'b1, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "restart_hold");
    add_vec(1,  1'b1, 2'b00, 1'b0, 3'b110, 2'd1, 1'b0, "restart_rel0");
    add_vec(3,  1'b1, 2'b00, 1'b0, 3'b110, 2'd1, 1'b0, "release_stage1");
    add_vec(1,  1'b1, 2'b00, 1'b1, 3'b111, 2'd0, 1'b0, "sw_rst_reassert");
    add_vec(1,  1'b1, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "sw_rst_e0");
    add_vec(15, 1'b1, 2'b00, 1'b0, 3'b111, 2'd0, 1'b0, "sw_hold");
    add_vec(1,  1'b1, 2'b00, 1'b0, 3'b110, 2'd1, 1'b0, "sw_rel0");
    add_vec(8,  1'b1, 2'b00, 1'b0, 3'b100, 2'd2, 1'b0, "sw_rel1");
    add_vec(8,  1'b1, 2'b00, 1'b0, 3'b000, 2'd3, 1'b1, "sw_done");

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      a_srst_n = tbl[i].srst_n;
      a_req    = tbl[i].req;
      a_sw     = tbl[i].sw;
      step_a(tbl[i].n, tbl[i].e_srst, tbl[i].e_stage, tbl[i].e_done, tbl[i].name);
    end

    // Request toggling faster than the hold time never lets anything release.
    a_req = 2'b01;
    step_a(10, 3'b111, 2'd0, 1'b0, "toggle_first_high");
    for (int t = 0; t < 6; t++) begin
      a_req[0] = ~a_req[0];
      for (int c = 0; c < 10; c++) step_a(1, 3'b111, 2'd0, 1'b0, "toggle_no_release");
    end
    a_req = 2'b00;

    // Polarity instance: idle request pattern 2'b10 is inactive.
    step_b(3,  3'b010, 2'd0, 1'b0, "pol_reset_value");
    b_srst_n = 1'b1;
    step_b(3,  3'b010, 2'd0, 1'b0, "pol_e0");
    step_b(15, 3'b010, 2'd0, 1'b0, "pol_hold");
    step_b(1,  3'b011, 2'd1, 1'b0, "pol_rel0");
    step_b(16, 3'b101, 2'd3, 1'b1, "pol_final");
    b_req = 2'b11;
    step_b(2,  3'b101, 2'd3, 1'b1, "pol_req_syncing");
    step_b(1,  3'b010, 2'd0, 1'b0, "pol_req_reassert");

    // Single output with one-cycle hold, plus reset dropped mid-HOLD.
    step_c(3, 1'b1, 1'b0, 1'b0, "one_reset");
    c_srst_n = 1'b1;
    step_c(3, 1'b1, 1'b0, 1'b0, "one_e0");
    step_c(1, 1'b0, 1'b1, 1'b1, "one_release_e0p1");
    c_srst_n = 1'b0;
    step_c(1, 1'b1, 1'b0, 1'b0, "one_reset_from_done");
    c_srst_n = 1'b1;
    step_c(3, 1'b1, 1'b0, 1'b0, "one_in_hold");
    c_srst_n = 1'b0;
    step_c(1, 1'b1, 1'b0, 1'b0, "one_reset_mid_hold");
    c_srst_n = 1'b1;
    step_c(3, 1'b1, 1'b0, 1'b0, "one_e0_again");
    step_c(1, 1'b0, 1'b1, 1'b1, "one_release_again");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
